// File: rtl/updi_tx.sv
// updi_tx: byte-to-line serializer for the UPDI single-wire link.
// Frame: 1 start, 8 data bits LSB-first, even parity, STOP_BITS stop bits.
// A one-byte holding register lets consecutive frames leave back-to-back.
// Optional macro UPDI_TX_BREAK_EN adds the break_req input and a BREAK state
// (line held low for BREAK_BITS bit periods, then STOP_BITS high).
module updi_tx #(
  parameter int STOP_BITS  = 2,
  parameter int BREAK_BITS = 12
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
`ifdef UPDI_TX_BREAK_EN
  input  logic       break_req,
`endif
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_out,
  output logic       tx_oe,
  output logic       tx_done
);

  // One counter serves both the stop-bit and the break-length phases.
  localparam int CNT_MAX = (BREAK_BITS > STOP_BITS) ? BREAK_BITS : STOP_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
`ifdef UPDI_TX_BREAK_EN
  localparam logic [CNT_W-1:0] BREAK_LAST = CNT_W'(BREAK_BITS - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UPDI_TX_BREAK_EN
    , BREAK
`endif
  } state_t;

  state_t           state;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] cnt;
  logic             pending;
  logic [7:0]       hold;
  logic [7:0]       shift;
  logic             par_bit;

  logic brk;
  logic accept;
  logic last_stop;
  logic load;
  logic pending_nxt;

`ifdef UPDI_TX_BREAK_EN
  assign brk = break_req;
`else
  assign brk = 1'b0;
`endif

  assign accept    = tx_valid && tx_ready;
  assign last_stop = (state == STOP) && (cnt == STOP_LAST);
  // A pending byte moves into the shifter either from IDLE (when no break is
  // requested) or straight off the last stop bit for gapless frames.
  assign load      = baud_tick && pending && (((state == IDLE) && !brk) || last_stop);
  // accept needs an empty holder and load needs a full one, so they never collide.
  assign pending_nxt = accept || (pending && !load);

  // Datapath registers: holding byte, shifter and parity; no reset needed.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      hold <= tx_data;
    end
    if (load) begin
      shift   <= hold;
      par_bit <= ^hold;
    end else if (baud_tick && ((state == START) || (state == DATA))) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

  // Frame FSM with registered line, output-enable and handshake outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      bit_idx  <= 3'd0;
      cnt      <= '0;
      tx_out   <= 1'b1;
      tx_oe    <= 1'b0;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      tx_ready <= !pending_nxt;
      tx_busy  <= (state != IDLE) || pending_nxt;
      tx_done  <= 1'b0;
      if (baud_tick) begin
        case (state)
          IDLE: begin
`ifdef UPDI_TX_BREAK_EN
            if (break_req) begin
              state   <= BREAK;
              cnt     <= '0;
              tx_out  <= 1'b0;
              tx_oe   <= 1'b1;
              tx_busy <= 1'b1;
            end else
`endif
            if (pending) begin
              state   <= START;
              tx_out  <= 1'b0;
              tx_oe   <= 1'b1;
              tx_busy <= 1'b1;
            end
          end
          START: begin
            state   <= DATA;
            bit_idx <= 3'd0;
            tx_out  <= shift[0];
          end
          DATA: begin
            if (bit_idx == 3'd7) begin
              state  <= PARITY;
              tx_out <= par_bit;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_out  <= shift[0];
            end
          end
          PARITY: begin
            state  <= STOP;
            cnt    <= '0;
            tx_out <= 1'b1;
          end
          STOP: begin
            if (cnt == STOP_LAST) begin
              tx_done <= 1'b1;
              if (pending) begin
                state  <= START;
                tx_out <= 1'b0;
              end else begin
                state   <= IDLE;
                tx_out  <= 1'b1;
                tx_oe   <= 1'b0;
                tx_busy <= pending_nxt;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef UPDI_TX_BREAK_EN
          BREAK: begin
            if (cnt == BREAK_LAST) begin
              state  <= STOP;
              cnt    <= '0;
              tx_out <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          default: begin
            state  <= IDLE;
            tx_out <= 1'b1;
            tx_oe  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_updi_tx.sv
// tb_updi_tx: directed self-checking bench for updi_tx (STOP_BITS=2, BREAK_BITS=12).
// The break scenario is compiled in only when UPDI_TX_BREAK_EN is defined.
module tb_updi_tx;
  logic       clk_in    = 1'b0;
  logic       rst       = 1'b1;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_valid  = 1'b0;
  logic       tx_ready, tx_busy, tx_out, tx_oe, tx_done;
`ifdef UPDI_TX_BREAK_EN
  logic       break_req = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  int   div       = 4;
  bit   tick_en   = 1'b0;
  int   phase     = 0;
  logic edge_tick = 1'b0;

  updi_tx #(.STOP_BITS(2), .BREAK_BITS(12)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .baud_tick(baud_tick),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
`ifdef UPDI_TX_BREAK_EN
    .break_req(break_req),
`endif
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .tx_out   (tx_out),
    .tx_oe    (tx_oe),
    .tx_done  (tx_done)
  );

  always #5 clk_in = ~clk_in;

  // Bit-period pulse generator standing in for the clock divider.
  always @(negedge clk_in) begin
    if (tick_en) begin
      if (phase >= div - 1) begin
        baud_tick = 1'b1;
        phase = 0;
      end else begin
        baud_tick = 1'b0;
        phase = phase + 1;
      end
    end else begin
      baud_tick = 1'b0;
      phase = 0;
    end
  end

  // Remember whether the most recent rising edge carried a tick.
  always @(posedge clk_in) edge_tick <= baud_tick;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic next_clk();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      next_clk();
      if (edge_tick === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_oe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      next_clk();
      if (tx_oe === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_in);
      if (tx_ready === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge clk_in);
      #1;
      tx_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick_en = 1'b0;
    repeat (3) next_clk();
    total++; if (tx_out   !== 1'b1) begin bad++; $display("FAIL reset_tx_out: got %b want 1", tx_out); end
    total++; if (tx_oe    !== 1'b0) begin bad++; $display("FAIL reset_tx_oe: got %b want 0", tx_oe); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    total++; if (tx_busy  !== 1'b0) begin bad++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    total++; if (tx_done  !== 1'b0) begin bad++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
    rst = 1'b0;
    next_clk();
    total++; if (tx_out !== 1'b1 || tx_oe !== 1'b0) begin bad++; $display("FAIL idle_after_reset: got out=%b oe=%b want out=1 oe=0", tx_out, tx_oe); end
  endtask

  task automatic test_frame_55();
    logic [0:11] exp_bits = 12'b0101_0101_0011;
    bit ok;
    int oe_cnt = 0;
    int done_cnt = 0;
    int done_at = -1;
    div = 4;
    tick_en = 1'b1;
    send_byte(8'h55, ok);
    if (!ok) begin total++; bad++; $display("FAIL f55_accept: got timeout want accept"); return; end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL f55_ready_after_accept: got %b want 0", tx_ready); end
    total++; if (tx_busy  !== 1'b1) begin bad++; $display("FAIL f55_busy_after_accept: got %b want 1", tx_busy); end
    wait_oe(ok);
    if (!ok) begin total++; bad++; $display("FAIL f55_start: got timeout want tx_oe=1"); return; end
    for (int i = 0; i < 60; i++) begin
      if (i > 0) next_clk();
      if (i < 48) begin
        total++;
        if (tx_out !== exp_bits[i / 4]) begin bad++; $display("FAIL f55_bit clk %0d: got %b want %b", i, tx_out, exp_bits[i / 4]); end
      end
      if (tx_oe === 1'b1) oe_cnt++;
      if (tx_done === 1'b1) begin done_cnt++; done_at = i; end
    end
    total++; if (oe_cnt   != 48) begin bad++; $display("FAIL f55_oe_len: got %0d want 48", oe_cnt); end
    total++; if (done_cnt != 1)  begin bad++; $display("FAIL f55_done_count: got %0d want 1", done_cnt); end
    total++; if (done_at  != 48) begin bad++; $display("FAIL f55_done_pos: got %0d want 48", done_at); end
  endtask

  task automatic test_parity();
    logic [7:0] vals [4] = '{8'h01, 8'h00, 8'hFF, 8'h80};
    logic       pexp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit ok;
    bit seen;
    div = 2;
    tick_en = 1'b1;
    for (int v = 0; v < 4; v++) begin
      send_byte(vals[v], ok);
      if (!ok) begin total++; bad++; $display("FAIL parity_accept %02h: got timeout want accept", vals[v]); continue; end
      wait_oe(ok);
      if (!ok) begin total++; bad++; $display("FAIL parity_start %02h: got timeout want tx_oe=1", vals[v]); continue; end
      for (int k = 0; k < 9 && ok; k++) wait_tick(ok);
      if (!ok) begin total++; bad++; $display("FAIL parity_ticks %02h: got timeout want ticks", vals[v]); continue; end
      total++;
      if (tx_out !== pexp[v]) begin bad++; $display("FAIL parity_bit %02h: got %b want %b", vals[v], tx_out, pexp[v]); end
      seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
        next_clk();
        if (tx_done === 1'b1) seen = 1'b1;
      end
      if (!seen) begin total++; bad++; $display("FAIL parity_done %02h: got no tx_done want pulse", vals[v]); end
      next_clk();
    end
  endtask

  task automatic test_back_to_back();
    logic [0:23] exp_bits = {12'b0101_0010_1011, 12'b0001_1110_0011};
    bit ok_a, ok_b, ok_oe;
    int oe_cnt = 0;
    int done_cnt = 0;
    int d0 = -1;
    int d1 = -1;
    logic oe_end = 1'b1;
    div = 4;
    tick_en = 1'b1;
    send_byte(8'hA5, ok_a);
    if (!ok_a) begin total++; bad++; $display("FAIL b2b_accept_a5: got timeout want accept"); return; end
    fork
      send_byte(8'h3C, ok_b);
      begin
        wait_oe(ok_oe);
        if (ok_oe) begin
          for (int i = 0; i < 110; i++) begin
            if (i > 0) next_clk();
            if (i < 96) begin
              total++;
              if (tx_out !== exp_bits[i / 4]) begin bad++; $display("FAIL b2b_bit clk %0d: got %b want %b", i, tx_out, exp_bits[i / 4]); end
              if (tx_oe === 1'b1) oe_cnt++;
            end
            if (i == 100) oe_end = tx_oe;
            if (tx_done === 1'b1) begin
              done_cnt++;
              if (d0 < 0) d0 = i; else d1 = i;
            end
          end
        end
      end
    join
    if (!ok_b)  begin total++; bad++; $display("FAIL b2b_accept_3c: got timeout want accept"); end
    if (!ok_oe) begin total++; bad++; $display("FAIL b2b_start: got timeout want tx_oe=1"); return; end
    total++; if (oe_cnt   != 96)   begin bad++; $display("FAIL b2b_oe_continuous: got %0d want 96", oe_cnt); end
    total++; if (done_cnt != 2)    begin bad++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
    total++; if (d0 != 48 || d1 != 96) begin bad++; $display("FAIL b2b_done_pos: got %0d,%0d want 48,96", d0, d1); end
    total++; if (oe_end   !== 1'b0) begin bad++; $display("FAIL b2b_oe_release: got %b want 0", oe_end); end
  endtask

  task automatic test_reset_mid();
    logic [0:11] exp_bits = 12'b0110_0001_1011;
    bit ok;
    int done_cnt = 0;
    int oe_cnt = 0;
    div = 4;
    tick_en = 1'b1;
    send_byte(8'h96, ok);
    if (!ok) begin total++; bad++; $display("FAIL rmid_accept: got timeout want accept"); return; end
    wait_oe(ok);
    for (int k = 0; k < 4 && ok; k++) wait_tick(ok);
    if (!ok) begin total++; bad++; $display("FAIL rmid_ticks: got timeout want ticks"); return; end
    total++; if (tx_out !== 1'b0) begin bad++; $display("FAIL rmid_bit3: got %b want 0", tx_out); end
    rst = 1'b1;
    next_clk();
    rst = 1'b0;
    total++; if (tx_out   !== 1'b1) begin bad++; $display("FAIL rmid_tx_out: got %b want 1", tx_out); end
    total++; if (tx_oe    !== 1'b0) begin bad++; $display("FAIL rmid_tx_oe: got %b want 0", tx_oe); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rmid_tx_ready: got %b want 1", tx_ready); end
    total++; if (tx_busy  !== 1'b0) begin bad++; $display("FAIL rmid_tx_busy: got %b want 0", tx_busy); end
    total++; if (tx_done  !== 1'b0) begin bad++; $display("FAIL rmid_tx_done: got %b want 0", tx_done); end
    for (int i = 0; i < 40; i++) begin
      next_clk();
      if (tx_done === 1'b1) done_cnt++;
      if (tx_oe === 1'b1) oe_cnt++;
    end
    total++; if (done_cnt != 0 || oe_cnt != 0) begin bad++; $display("FAIL rmid_quiet: got done=%0d oe=%0d want 0,0", done_cnt, oe_cnt); end
    send_byte(8'hC3, ok);
    if (!ok) begin total++; bad++; $display("FAIL rmid_accept_c3: got timeout want accept"); return; end
    wait_oe(ok);
    if (!ok) begin total++; bad++; $display("FAIL rmid_start_c3: got timeout want tx_oe=1"); return; end
    for (int k = 0; k < 13; k++) begin
      if (k > 0) begin
        wait_tick(ok);
        if (!ok) begin total++; bad++; $display("FAIL rmid_tick_c3: got timeout want tick %0d", k); return; end
      end
      if (k < 12) begin
        total++;
        if (tx_out !== exp_bits[k]) begin bad++; $display("FAIL rmid_c3_bit %0d: got %b want %b", k, tx_out, exp_bits[k]); end
      end else begin
        total++;
        if (tx_done !== 1'b1 || tx_oe !== 1'b0) begin bad++; $display("FAIL rmid_c3_end: got done=%b oe=%b want 1,0", tx_done, tx_oe); end
      end
    end
  endtask

  task automatic test_hold();
    logic [0:11] exp_bits = 12'b0010_1101_0011;
    bit ok, ok_oe;
    int oe_cnt = 0;
    int done_cnt = 0;
    logic busy_end = 1'b1;
    div = 4;
    tick_en = 1'b1;
    send_byte(8'h5A, ok);
    if (!ok) begin total++; bad++; $display("FAIL hold_accept: got timeout want accept"); return; end
    fork
      begin
        for (int n = 0; n < 56; n++) begin
          @(negedge clk_in);
          tx_data  = tx_data ^ 8'hFF;
          tx_valid = (tx_ready === 1'b1) ? 1'b0 : ~tx_valid;
        end
        tx_valid = 1'b0;
      end
      begin
        wait_oe(ok_oe);
        if (ok_oe) begin
          for (int i = 0; i < 70; i++) begin
            if (i > 0) next_clk();
            if (i < 48) begin
              total++;
              if (tx_out !== exp_bits[i / 4]) begin bad++; $display("FAIL hold_bit clk %0d: got %b want %b", i, tx_out, exp_bits[i / 4]); end
            end
            if (tx_oe === 1'b1) oe_cnt++;
            if (tx_done === 1'b1) done_cnt++;
          end
          busy_end = tx_busy;
        end
      end
    join
    if (!ok_oe) begin total++; bad++; $display("FAIL hold_start: got timeout want tx_oe=1"); return; end
    total++; if (oe_cnt   != 48)   begin bad++; $display("FAIL hold_oe_len: got %0d want 48", oe_cnt); end
    total++; if (done_cnt != 1)    begin bad++; $display("FAIL hold_done_count: got %0d want 1", done_cnt); end
    total++; if (busy_end !== 1'b0) begin bad++; $display("FAIL hold_no_extra: got busy=%b want 0", busy_end); end
  endtask

  task automatic test_div1();
    logic [0:11] exp_bits = 12'b0110_0001_1011;
    bit ok;
    int oe_cnt = 0;
    int done_at = -1;
    div = 1;
    tick_en = 1'b1;
    send_byte(8'hC3, ok);
    if (!ok) begin total++; bad++; $display("FAIL div1_accept: got timeout want accept"); return; end
    wait_oe(ok);
    if (!ok) begin total++; bad++; $display("FAIL div1_start: got timeout want tx_oe=1"); return; end
    for (int i = 0; i < 16; i++) begin
      if (i > 0) next_clk();
      if (i < 12) begin
        total++;
        if (tx_out !== exp_bits[i]) begin bad++; $display("FAIL div1_bit %0d: got %b want %b", i, tx_out, exp_bits[i]); end
      end
      if (tx_oe === 1'b1) oe_cnt++;
      if (tx_done === 1'b1) done_at = i;
    end
    total++; if (oe_cnt  != 12) begin bad++; $display("FAIL div1_oe_len: got %0d want 12", oe_cnt); end
    total++; if (done_at != 12) begin bad++; $display("FAIL div1_done_pos: got %0d want 12", done_at); end
  endtask

`ifdef UPDI_TX_BREAK_EN
  task automatic test_break();
    logic [0:25] exp_bits = {12'b0000_0000_0000, 2'b11, 12'b0101_0101_0011};
    bit ok;
    div = 2;
    tick_en = 1'b1;
    @(negedge clk_in);
    break_req = 1'b1;
    tx_data   = 8'h55;
    tx_valid  = 1'b1;
    @(posedge clk_in);
    #1;
    tx_valid = 1'b0;
    wait_oe(ok);
    break_req = 1'b0;
    if (!ok) begin total++; bad++; $display("FAIL brk_start: got timeout want tx_oe=1"); return; end
    for (int k = 0; k < 27; k++) begin
      if (k > 0) begin
        wait_tick(ok);
        if (!ok) begin total++; bad++; $display("FAIL brk_tick: got timeout want tick %0d", k); return; end
      end
      if (k < 26) begin
        total++;
        if (tx_out !== exp_bits[k]) begin bad++; $display("FAIL brk_line %0d: got %b want %b", k, tx_out, exp_bits[k]); end
      end
      if (k == 14) begin
        total++;
        if (tx_done !== 1'b1) begin bad++; $display("FAIL brk_done: got %b want 1", tx_done); end
      end
      if (k == 26) begin
        total++;
        if (tx_done !== 1'b1 || tx_oe !== 1'b0) begin bad++; $display("FAIL brk_frame_end: got done=%b oe=%b want 1,0", tx_done, tx_oe); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_55();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    test_div1();
`ifdef UPDI_TX_BREAK_EN
    test_break();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updi_tx.md
Name: updi_tx

Overview:
- Byte-to-line serializer for the UPDI single-wire link.
- Consumes the one-cycle bit-period pulse produced by the clock divider (divider output wired to baud_tick) and shifts out UPDI frames: 1 start, 8 data LSB-first, even parity, STOP_BITS stop.
- A one-byte holding register decouples the upstream command sequencer, so consecutive frames go out back-to-back with no idle bit between them.
- Drives the line value and a pad output-enable for the half-duplex UPDI pin.

Parameters:
- STOP_BITS, 2, number of stop bits per frame (1 or 2).
- BREAK_BITS, 12, bit periods the line is held low for a BREAK (used only with the optional feature).

Ports:
- clk_in  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- baud_tick  input  1  one-cycle pulse once per bit period, from the clock divider.
- tx_data  input  8  byte to send.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding register empty; byte accepted when tx_valid && tx_ready.
- tx_busy  output  1  frame on line or byte pending.
- tx_out  output  1  serial line value; idle high.
- tx_oe  output  1  pad output-enable; high only while a frame or break is driven.
- tx_done  output  1  one-cycle pulse at the end of each frame or break.

Behaviour:
- Everything is synchronous to clk_in; all outputs are registered.
- Reset values: tx_out=1, tx_oe=0, tx_ready=1, tx_busy=0, tx_done=0. State=IDLE, holding register empty.
- Reset mid-frame aborts the frame immediately (next cycle line idle, no tx_done).
- Holding register:
  - On accept, tx_data is latched and tx_ready goes to 0 the next cycle.
  - tx_data changes after acceptance have no effect on the line.
- States: IDLE, START, DATA, PARITY, STOP, and BREAK (optional feature only).
- State changes happen only on clock edges where baud_tick=1. tx_out/tx_oe update on that same edge.
- IDLE:
  - Tick with byte pending → START: tx_out=0, tx_oe=1, byte moved to shift register, holding register freed (tx_ready=1 next cycle).
  - A byte accepted in the same cycle as a tick does not start until the next tick.
- START, tick → DATA bit 0. DATA: 8 ticks, tx_out = shift[0], shift right each tick, 3-bit index.
- After DATA bit 7, tick → PARITY: tx_out = XOR of the 8 data bits (even parity).
- PARITY, tick → STOP: tx_out=1, for STOP_BITS ticks.
- Tick ending the last stop bit:
  - tx_done=1 for exactly that following cycle.
  - If a byte is pending, go directly to START (gapless).
  - Otherwise go to IDLE with tx_oe=0, tx_out=1.
- Frame length: exactly 10+STOP_BITS bit periods (12 by default).
- tx_busy = (state != IDLE) || pending.
- tx_valid while tx_ready=0 is ignored; upstream must hold the byte.
- baud_tick asserted on consecutive cycles (DIV=1) is legal: one bit per clock.

Optional Feature:
- Macro: UPDI_TX_BREAK_EN.
- Defined: adds input port break_req (1 bit, level).
  - Sampled in IDLE on a tick, break_req takes priority over a pending byte.
  - BREAK state: tx_out=0, tx_oe=1 for BREAK_BITS ticks, then tx_out=1 for STOP_BITS ticks, then tx_done pulse.
  - Pending byte starts at the following tick. Frames in progress are never interrupted by break_req.
- Undefined: break_req port and BREAK state do not exist; no break capability.

Test Plan:
- 0x55 sent, baud_tick every 4 clocks → tx_out bits 0,1,0,1,0,1,0,1,0,0(parity),1,1, each held 4 clocks; tx_oe high 48 clocks; single tx_done.
- Parity check: 0x01 → parity bit 1; 0x00 → 0; 0xFF → 0; 0x80 → 1.
- Two bytes 0xA5, 0x3C presented back-to-back → second START immediately follows the last stop bit of the first (no idle period); tx_oe never drops between frames; two tx_done pulses 12 ticks apart.
- rst asserted during DATA bit 3 → next cycle tx_out=1, tx_oe=0, tx_ready=1, tx_busy=0; no tx_done; a new byte afterwards transmits correctly.
- tx_data toggled every cycle after acceptance, and tx_valid pulsed while tx_ready=0 → line carries only the accepted byte; extra pulses are dropped.
- UPDI_TX_BREAK_EN defined, break_req and tx_valid (0x55) raised together in IDLE → 12 low ticks, 2 high ticks, tx_done, then the 0x55 frame.
